depar_pkt_arbiter: RTL and testbench

- Packet-granular round-robin arbiter that shares one deparser packet-FIFO read port among NUM_PORTS upstream packet FIFOs (first-word-fall-through).
- Sits between the per-source packet FIFOs and the deparser segment-splitter. It presents a single FIFO-style interface (data/empty/rd_en) to that splitter.
- Once a port is granted, the grant is held until that packet's tlast segment is read, so segments never interleave.

---
 rtl/depar_pkt_arbiter.sv | 122 ++++++++++++
 tb/tb_depar_pkt_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/depar_pkt_arbiter.sv
// Packet-granular round-robin arbiter that merges NUM_PORTS FWFT packet FIFOs
// into one FIFO-style read port for the deparser segment splitter.
module depar_pkt_arbiter #(
  parameter int C_AXIS_DATA_WIDTH  = 512,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_PORTS          = 4,
  parameter int PORT_ID_W          = 2
) (
  input  logic                                     clk,
  input  logic                                     areset,
  input  logic [NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]   in_tdata,
  input  logic [NUM_PORTS*C_AXIS_TUSER_WIDTH-1:0]  in_tuser,
  input  logic [NUM_PORTS*C_AXIS_DATA_WIDTH/8-1:0] in_tkeep,
  input  logic [NUM_PORTS-1:0]                     in_tlast,
  input  logic [NUM_PORTS-1:0]                     in_empty,
  output logic [NUM_PORTS-1:0]                     in_rd_en,
  output logic [C_AXIS_DATA_WIDTH-1:0]             out_tdata,
  output logic [C_AXIS_TUSER_WIDTH-1:0]            out_tuser,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]           out_tkeep,
  output logic                                     out_tlast,
  output logic                                     out_empty,
  input  logic                                     out_rd_en,
  output logic [PORT_ID_W-1:0]                     grant_id,
  output logic                                     busy,
  output logic [NUM_PORTS*32-1:0]                  pkt_cnt,
  output logic                                     err_rd_empty
);

  localparam int DW = C_AXIS_DATA_WIDTH;
  localparam int UW = C_AXIS_TUSER_WIDTH;
  localparam int KW = C_AXIS_DATA_WIDTH / 8;
  localparam logic [PORT_ID_W:0]   NP_EXT    = (PORT_ID_W+1)'(NUM_PORTS);
  localparam logic [PORT_ID_W-1:0] LAST_PORT = PORT_ID_W'(NUM_PORTS - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state, state_next;
  logic [PORT_ID_W-1:0]   rr_ptr;
  logic [PORT_ID_W-1:0]   winner;
  logic [PORT_ID_W-1:0]   offset;
  logic [PORT_ID_W:0]     winner_sum;
  logic [2*NUM_PORTS-1:0] req_rot;
  logic                   any_req;
  logic                   rd_fire;
  logic                   pkt_end;
  logic [31:0]            cnt [NUM_PORTS];

  // Rotate the request vector so bit 0 is rr_ptr; the lowest set bit wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    req_rot    = {~in_empty, ~in_empty} >> rr_ptr;
    any_req    = |req_rot[NUM_PORTS-1:0];
    offset     = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (req_rot[k]) offset = PORT_ID_W'(k);
    end
    winner_sum = {1'b0, rr_ptr} + {1'b0, offset};
    if (winner_sum >= NP_EXT) winner_sum = winner_sum - NP_EXT;
    winner     = winner_sum[PORT_ID_W-1:0];
  end

  always_comb begin
    out_tdata = '0;
    out_tuser = '0;
    out_tkeep = '0;
    out_tlast = 1'b0;
    out_empty = 1'b1;
    in_rd_en  = '0;
    if (state == BUSY) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (grant_id == PORT_ID_W'(i)) begin
          out_tdata = in_tdata[i*DW +: DW];
          out_tuser = in_tuser[i*UW +: UW];
          out_tkeep = in_tkeep[i*KW +: KW];
          out_tlast = in_tlast[i];
          out_empty = in_empty[i];
        end
      end
    end
    rd_fire = out_rd_en & ~out_empty;
    pkt_end = rd_fire & out_tlast;
    for (int i = 0; i < NUM_PORTS; i++) begin
      in_rd_en[i] = rd_fire && (grant_id == PORT_ID_W'(i));
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = BUSY;
      BUSY:    if (pkt_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
      state        <= IDLE;
      grant_id     <= '0;
      rr_ptr       <= '0;
      err_rd_empty <= 1'b0;
      // NOTE: the counter array is software-visible, so unlike a data memory it is reset.
      for (int i = 0; i < NUM_PORTS; i++) cnt[i] <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && any_req) grant_id <= winner;
      if (pkt_end) begin
        cnt[grant_id] <= cnt[grant_id] + 32'd1;
        rr_ptr        <= (grant_id == LAST_PORT) ? '0 : grant_id + PORT_ID_W'(1);
      end
      if (out_rd_en && out_empty) err_rd_empty <= 1'b1;
    end
  end

  assign busy = (state == BUSY);

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt
    assign pkt_cnt[g*32 +: 32] = cnt[g];
  end

endmodule

// File: tb/tb_depar_pkt_arbiter.sv
// Directed bench for depar_pkt_arbiter: FWFT FIFO models per port, a
// cycle table for the single-port case and hand sequences for the rest.
module tb_depar_pkt_arbiter;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int UW = 8;
  localparam int KW = DW / 8;

  logic               clk = 1'b0;
  logic               areset;
  logic [NP*DW-1:0]   in_tdata;
  logic [NP*UW-1:0]   in_tuser;
  logic [NP*KW-1:0]   in_tkeep;
  logic [NP-1:0]      in_tlast;
  logic [NP-1:0]      in_empty;
  logic [NP-1:0]      in_rd_en;
  logic [DW-1:0]      out_tdata;
  logic [UW-1:0]      out_tuser;
  logic [KW-1:0]      out_tkeep;
  logic               out_tlast;
  logic               out_empty;
  logic               out_rd_en;
  logic [1:0]         grant_id;
  logic               busy;
  logic [NP*32-1:0]   pkt_cnt;
  logic               err_rd_empty;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } seg_t;

  typedef struct {
    logic       rd;
    logic       oe;
    logic [3:0] ird;
    logic       tl;
    logic       bz;
    logic [1:0] gid;
    logic       err;
  } vec_t;

  seg_t fifo [NP][$];
  vec_t sp_vec [5];
  int   order [3] = '{0, 2, 3};

  always #5 clk = ~clk;

  depar_pkt_arbiter #(
    .C_AXIS_DATA_WIDTH (DW),
    .C_AXIS_TUSER_WIDTH(UW),
    .NUM_PORTS         (NP),
    .PORT_ID_W         (2)
  ) dut (
    .clk         (clk),
    .areset      (areset),
    .in_tdata    (in_tdata),
    .in_tuser    (in_tuser),
    .in_tkeep    (in_tkeep),
    .in_tlast    (in_tlast),
    .in_empty    (in_empty),
    .in_rd_en    (in_rd_en),
    .out_tdata   (out_tdata),
    .out_tuser   (out_tuser),
    .out_tkeep   (out_tkeep),
    .out_tlast   (out_tlast),
    .out_empty   (out_empty),
    .out_rd_en   (out_rd_en),
    .grant_id    (grant_id),
    .busy        (busy),
    .pkt_cnt     (pkt_cnt),
    .err_rd_empty(err_rd_empty)
  );

  function automatic logic [DW-1:0] mk(int p, int k, int s);
    return {8'(p), 8'(k), 8'(s), 8'hA5};
  endfunction

  function automatic logic [UW-1:0] mk_user(int p, int s);
    return {4'(p), 4'(s)};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NP; i++) begin
      if (fifo[i].size() > 0) begin
        in_empty[i]           = 1'b0;
        in_tdata[i*DW +: DW]  = fifo[i][0].data;
        in_tuser[i*UW +: UW]  = mk_user(int'(fifo[i][0].data[31:24]), int'(fifo[i][0].data[15:8]));
        in_tkeep[i*KW +: KW]  = '1;
        in_tlast[i]           = fifo[i][0].last;
      end else begin
        in_empty[i]           = 1'b1;
        in_tdata[i*DW +: DW]  = '0;
        in_tuser[i*UW +: UW]  = '0;
        in_tkeep[i*KW +: KW]  = '0;
        in_tlast[i]           = 1'b0;
      end
    end
  endtask

  task automatic push_seg(int p, int k, int s, logic last);
    seg_t e;
    e.data = mk(p, k, s);
    e.last = last;
    fifo[p].push_back(e);
    drive();
  endtask

  task automatic push_pkt(int p, int k, int nseg);
    for (int s = 0; s < nseg; s++) push_seg(p, k, s, s == nseg - 1);
  endtask

  // One clock: capture the read strobes at the edge, then pop the FIFO models.
  task automatic tick();
    logic [NP-1:0] r;
    @(posedge clk);
    r = in_rd_en;
    #1;
    for (int i = 0; i < NP; i++) begin
      if (r[i] && fifo[i].size() > 0) void'(fifo[i].pop_front());
    end
    drive();
  endtask

  task automatic do_reset();
    areset    = 1'b1;
    out_rd_en = 1'b0;
    for (int i = 0; i < NP; i++) fifo[i].delete();
    drive();
    repeat (2) @(posedge clk);
    #1;
    areset = 1'b0;
  endtask

  initial begin
    sp_vec[0] = '{rd: 1'b1, oe: 1'b1, ird: 4'b0000, tl: 1'b0, bz: 1'b0, gid: 2'd0, err: 1'b0};
    sp_vec[1] = '{rd: 1'b1, oe: 1'b0, ird: 4'b0001, tl: 1'b0, bz: 1'b1, gid: 2'd0, err: 1'b1};
    sp_vec[2] = '{rd: 1'b1, oe: 1'b0, ird: 4'b0001, tl: 1'b0, bz: 1'b1, gid: 2'd0, err: 1'b1};
    sp_vec[3] = '{rd: 1'b1, oe: 1'b0, ird: 4'b0001, tl: 1'b1, bz: 1'b1, gid: 2'd0, err: 1'b1};
    sp_vec[4] = '{rd: 1'b1, oe: 1'b1, ird: 4'b0000, tl: 1'b0, bz: 1'b0, gid: 2'd0, err: 1'b1};

    // Reset state
    do_reset();
    #1;
    check("rst_busy", busy, 0);
    check("rst_grant", grant_id, 0);
    check("rst_empty", out_empty, 1);
    check("rst_ird", in_rd_en, 0);
    check("rst_cnt", pkt_cnt, 0);
    check("rst_err", err_rd_empty, 0);

    // Single port, 3-segment packet, reads every cycle
    push_pkt(0, 0, 3);
    for (int c = 0; c < 5; c++) begin
      out_rd_en = sp_vec[c].rd;
      #1;
      check("sp_empty", out_empty, sp_vec[c].oe);
      check("sp_ird", in_rd_en, sp_vec[c].ird);
      check("sp_tlast", out_tlast, sp_vec[c].tl);
      check("sp_busy", busy, sp_vec[c].bz);
      check("sp_grant", grant_id, sp_vec[c].gid);
      check("sp_err", err_rd_empty, sp_vec[c].err);
      tick();
    end
    check("sp_cnt0", pkt_cnt[31:0], 1);
    check("sp_cnt_rest", pkt_cnt[127:32], 0);
    check("sp_rr_ptr", dut.rr_ptr, 1);

    // Contention: ports 0, 2, 3 each hold two 2-segment packets
    do_reset();
    for (int k = 0; k < 2; k++) begin
      push_pkt(0, k, 2);
      push_pkt(2, k, 2);
      push_pkt(3, k, 2);
    end
    out_rd_en = 1'b1;
    for (int c = 0; c < 18; c++) begin
      #1;
      if (c % 3 == 0) begin
        check("cont_bubble", out_empty, 1);
        check("cont_bubble_ird", in_rd_en, 0);
      end else begin
        check("cont_data", out_tdata, mk(order[(c / 3) % 3], c / 9, c % 3 - 1));
        check("cont_ird", in_rd_en, 64'(1) << order[(c / 3) % 3]);
        check("cont_tlast", out_tlast, (c % 3) == 2);
      end
      tick();
    end
    check("cont_cnt0", pkt_cnt[31:0], 2);
    check("cont_cnt1", pkt_cnt[63:32], 0);
    check("cont_cnt2", pkt_cnt[95:64], 2);
    check("cont_cnt3", pkt_cnt[127:96], 2);

    // Stall: port 1 runs dry mid-packet while port 0 waits
    do_reset();
    out_rd_en = 1'b1;
    push_seg(1, 0, 0, 1'b0);
    #1;
    check("stall_idle_busy", busy, 0);
    tick();
    push_pkt(0, 0, 1);
    #1;
    check("stall_grant", grant_id, 1);
    check("stall_seg0_ird", in_rd_en, 4'b0010);
    check("stall_seg0_data", out_tdata, mk(1, 0, 0));
    tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      check("stall_empty", out_empty, 1);
      check("stall_hold_grant", grant_id, 1);
      check("stall_ird", in_rd_en, 0);
      tick();
    end
    push_seg(1, 0, 1, 1'b1);
    #1;
    check("stall_resume_ird", in_rd_en, 4'b0010);
    check("stall_resume_tlast", out_tlast, 1);
    tick();
    #1;
    check("stall_release_busy", busy, 0);
    tick();
    #1;
    check("stall_next_grant", grant_id, 0);
    check("stall_next_ird", in_rd_en, 4'b0001);
    check("stall_next_data", out_tdata, mk(0, 0, 0));
    tick();
    check("stall_cnt1", pkt_cnt[63:32], 1);
    check("stall_cnt0", pkt_cnt[31:0], 1);

    // Deparser backpressure on port 2
    do_reset();
    push_pkt(2, 0, 2);
    tick();
    for (int c = 0; c < 4; c++) begin
      #1;
      check("bp_empty", out_empty, 0);
      check("bp_grant", grant_id, 2);
      check("bp_ird", in_rd_en, 0);
      check("bp_data", out_tdata, mk(2, 0, 0));
      check("bp_tuser", out_tuser, mk_user(2, 0));
      tick();
    end
    out_rd_en = 1'b1;
    #1;
    check("bp_rd_ird", in_rd_en, 4'b0100);
    tick();
    #1;
    check("bp_seg1_data", out_tdata, mk(2, 0, 1));
    check("bp_seg1_tkeep", out_tkeep, 4'hF);
    check("bp_seg1_tlast", out_tlast, 1);
    tick();
    #1;
    check("bp_release", busy, 0);
    check("bp_cnt2", pkt_cnt[95:64], 1);
    check("bp_no_err", err_rd_empty, 0);

    // Illegal read with all FIFOs empty
    do_reset();
    #1;
    check("ill_err_before", err_rd_empty, 0);
    out_rd_en = 1'b1;
    #1;
    check("ill_ird", in_rd_en, 0);
    tick();
    out_rd_en = 1'b0;
    #1;
    check("ill_err_set", err_rd_empty, 1);
    repeat (3) tick();
    check("ill_err_sticky", err_rd_empty, 1);
    check("ill_busy", busy, 0);

    // Async reset in segment 2 of 4 on port 3
    do_reset();
    out_rd_en = 1'b1;
    push_pkt(0, 0, 1);
    push_pkt(3, 0, 4);
    repeat (4) tick();
    #1;
    check("ar_pre_grant", grant_id, 3);
    check("ar_pre_ird", in_rd_en, 4'b1000);
    check("ar_pre_data", out_tdata, mk(3, 0, 1));
    check("ar_pre_cnt0", pkt_cnt[31:0], 1);
    check("ar_pre_err", err_rd_empty, 1);
    #2;
    areset = 1'b1;
    #1;
    check("ar_busy", busy, 0);
    check("ar_grant", grant_id, 0);
    check("ar_rr_ptr", dut.rr_ptr, 0);
    check("ar_cnt", pkt_cnt, 0);
    check("ar_err", err_rd_empty, 0);
    check("ar_ird", in_rd_en, 0);
    check("ar_empty", out_empty, 1);
    out_rd_en = 1'b0;
    #10;
    areset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
